// File: rtl/gpio_wb_banked.sv
// Banked Wishbone GPIO controller: per-bank pad synchroniser and debounce,
// atomic output ops, and edge interrupts.
module gpio_bank #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int SYNC_STAGES     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic [31:0] pad_i,
   input  logic        we,
   input  logic [3:0]  off,
   input  logic [31:0] wdat,
   input  logic [31:0] wmask,
   output logic [31:0] rdata,
   output logic [31:0] gpio_o,
   output logic [31:0] gpio_oe,
   output logic        irq
);
   logic [SYNC_STAGES-1:0][31:0] sync_q, sync_d;
   logic [31:0] samp_q, samp_d, db_q, db_d;
   logic [31:0] dout_q, dout_d, dir_q, dir_d, en_q, en_d, stat_q, stat_d, pol_q, pol_d;
   logic        irq_q, irq_d;
   logic [31:0] sync_out, stable, rise, fall, edge_hit, w1c;

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign stable   = ~(sync_out ^ samp_q);

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], pad_i};
      samp_d = samp_q;
      db_d   = db_q;
      if (DEBOUNCE_CYCLES == 0) begin
         db_d = sync_out;
      end else if (tick) begin
         samp_d = sync_out;
         // a bit only moves when two consecutive ticks agree
         db_d   = (db_q & ~stable) | (samp_q & stable);
      end
      rise     = db_d & ~db_q;
      fall     = ~db_d & db_q;
      edge_hit = (rise & pol_q) | (fall & ~pol_q);

      dout_d = dout_q;
      dir_d  = dir_q;
      en_d   = en_q;
      pol_d  = pol_q;
      w1c    = '0;
      if (we) begin
         case (off)
            4'd1: dout_d = (dout_q & ~wmask) | wdat;
            4'd2: dir_d  = (dir_q & ~wmask) | wdat;
            4'd3: dout_d = dout_q | wdat;
            4'd4: dout_d = dout_q & ~wdat;
            4'd5: dout_d = dout_q ^ wdat;
            4'd6: en_d   = (en_q & ~wmask) | wdat;
            4'd7: w1c    = wdat;
            4'd8: pol_d  = (pol_q & ~wmask) | wdat;
            default: ;
         endcase
      end
      // a new edge overrides a simultaneous clear
      stat_d = (stat_q & ~w1c) | (edge_hit & en_q);
      irq_d  = |(stat_q & en_q);

      case (off)
         4'd0:    rdata = db_q;
         4'd1:    rdata = dout_q;
         4'd2:    rdata = dir_q;
         4'd6:    rdata = en_q;
         4'd7:    rdata = stat_q;
         4'd8:    rdata = pol_q;
         default: rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         samp_q <= '0;
         db_q   <= '0;
         dout_q <= '0;
         dir_q  <= '0;
         en_q   <= '0;
         stat_q <= '0;
         pol_q  <= '1;
         irq_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         samp_q <= samp_d;
         db_q   <= db_d;
         dout_q <= dout_d;
         dir_q  <= dir_d;
         en_q   <= en_d;
         stat_q <= stat_d;
         pol_q  <= pol_d;
         irq_q  <= irq_d;
      end
   end

   assign gpio_o  = dout_q;
   assign gpio_oe = dir_q;
   assign irq     = irq_q;
endmodule

module gpio_wb_banked #(
   parameter int NUM_BANKS       = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int SYNC_STAGES     = 2,
   parameter int ADDR_WIDTH      = 32
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
   input  logic [31:0]             wb_dat_i,
   output logic [31:0]             wb_dat_o,
   input  logic                    wb_we_i,
   input  logic [3:0]              wb_sel_i,
   input  logic                    wb_stb_i,
   input  logic                    wb_cyc_i,
   output logic                    wb_ack_o,
   output logic                    wb_err_o,
   output logic                    wb_stall_o,
   input  logic [NUM_BANKS*32-1:0] gpio_i,
   output logic [NUM_BANKS*32-1:0] gpio_o,
   output logic [NUM_BANKS*32-1:0] gpio_oe,
   output logic [NUM_BANKS-1:0]    irq_bank_o,
   output logic                    intr
);
   logic [2:0]  bank;
   logic [3:0]  off;
   logic        req, bad, tick;
   logic        ack_q, ack_d, err_q, err_d;
   logic [31:0] dat_q, dat_d, wmask, wdat_m, rd_sel;
   logic [NUM_BANKS-1:0]       we_bank;
   logic [NUM_BANKS-1:0][31:0] rdata;
   logic        unused_adr;

   assign bank       = wb_adr_i[8:6];
   assign off        = wb_adr_i[5:2];
   assign unused_adr = ^{wb_adr_i[ADDR_WIDTH-1:9], wb_adr_i[1:0]};
   assign req        = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
   assign bad        = ({1'b0, bank} >= 4'(NUM_BANKS)) || (off > 4'd8);
   assign wmask      = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
   assign wdat_m     = wb_dat_i & wmask;

   if (DEBOUNCE_CYCLES > 0) begin : g_tick
      localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
      logic [CW-1:0] cnt_q, cnt_d;
      always_comb begin
         tick  = (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      end
      always_ff @(posedge wb_clk_i) begin
         if (wb_rst_i) cnt_q <= '0;
         else          cnt_q <= cnt_d;
      end
   end else begin : g_notick
      assign tick = 1'b1;
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      assign we_bank[b] = req & wb_we_i & ~bad & (bank == 3'(b));
      gpio_bank #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_bank (
         .clk    (wb_clk_i),
         .rst    (wb_rst_i),
         .tick   (tick),
         .pad_i  (gpio_i[b*32 +: 32]),
         .we     (we_bank[b]),
         .off    (off),
         .wdat   (wdat_m),
         .wmask  (wmask),
         .rdata  (rdata[b]),
         .gpio_o (gpio_o[b*32 +: 32]),
         .gpio_oe(gpio_oe[b*32 +: 32]),
         .irq    (irq_bank_o[b])
      );
   end

   always_comb begin
      rd_sel = '0;
      for (int b = 0; b < NUM_BANKS; b++)
         if (bank == 3'(b)) rd_sel = rdata[b];
      ack_d = 1'b0;
      err_d = 1'b0;
      dat_d = '0;
      if (req) begin
         ack_d = ~bad;
         err_d = bad;
         if (!bad && !wb_we_i) dat_d = rd_sel;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         dat_q <= '0;
      end else begin
         ack_q <= ack_d;
         err_q <= err_d;
         dat_q <= dat_d;
      end
   end

   assign wb_ack_o   = ack_q;
   assign wb_err_o   = err_q;
   assign wb_dat_o   = dat_q;
   assign wb_stall_o = 1'b0;
   assign intr       = |irq_bank_o;
endmodule

// File: tb/tb_gpio_wb_banked.sv
// Scoreboard bench for gpio_wb_banked: bus terminations are matched against queued expectations.
module tb_gpio_wb_banked;
   localparam int NB = 2, DEB = 16, SS = 2, AW = 32;

   logic clk = 1'b0, rst = 1'b1;
   logic [AW-1:0] adr;
   logic [31:0] dat_i, dat_o;
   logic we, stb, wb_cyc, ack, err, stall, intr;
   logic [3:0] sel;
   logic [NB*32-1:0] gi, go, goe;
   logic [NB-1:0] irqb;

   gpio_wb_banked #(.NUM_BANKS(NB), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SS), .ADDR_WIDTH(AW)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
      .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(wb_cyc), .wb_ack_o(ack),
      .wb_err_o(err), .wb_stall_o(stall), .gpio_i(gi), .gpio_o(go), .gpio_oe(goe),
      .irq_bank_o(irqb), .intr(intr));

   always #5 clk = ~clk;

   typedef struct packed { logic err; logic chkd; logic [31:0] dat; } exp_t;
   exp_t sbq[$];
   exp_t mon_e;
   int checks = 0, errors = 0;
   int ncyc = 0;
   int irq_cyc = 0;
   bit irq_seen = 1'b0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, act, exp);
      end
   endtask

   always @(posedge clk) ncyc <= ncyc + 1;

   always @(negedge clk) begin
      if (!irq_seen && irqb[1]) begin
         irq_seen <= 1'b1;
         irq_cyc  <= ncyc;
      end
   end

   always @(negedge clk) begin
      if (ack || err) begin
         if (sbq.size() == 0) chk("sb_spurious", {31'b0, ack | err}, 32'd0);
         else begin
            mon_e = sbq.pop_front();
            chk("term_err", {31'b0, err}, {31'b0, mon_e.err});
            chk("term_ack", {31'b0, ack}, {31'b0, ~mon_e.err});
            if (mon_e.chkd) chk("rd_dat", dat_o, mon_e.dat);
         end
      end
   end

   // starts just after a rising edge; request edge is the next one
   task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                      input logic e_err, input logic e_chkd, input logic [31:0] e_dat,
                      output logic [31:0] rd, output int rq_cyc);
      exp_t e;
      e.err = e_err; e.chkd = e_chkd; e.dat = e_dat;
      sbq.push_back(e);
      adr = a; we = w; dat_i = d; sel = s; stb = 1'b1; wb_cyc = 1'b1;
      @(posedge clk); #1;
      rd = dat_o;
      rq_cyc = ncyc;
      chk("term_lat", {31'b0, ack | err}, 32'd1);
      stb = 1'b0; wb_cyc = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      chk("term_once", {31'b0, ack | err}, 32'd0);
   endtask

   task automatic rd_exp(input logic [31:0] a, input logic [31:0] e);
      logic [31:0] d; int c;
      bus(a, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1, e, d, c);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r; int c;
      bus(a, 1'b1, d, s, 1'b0, 1'b0, 32'h0, r, c);
   endtask

   task automatic acc_err(input logic [31:0] a, input logic w, input logic [31:0] d);
      logic [31:0] r; int c;
      bus(a, w, d, 4'hF, 1'b1, 1'b1, 32'h0, r, c);
   endtask

   task automatic wait_to(input int target);
      while (ncyc < target) begin @(posedge clk); #1; end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [31:0] r;
      int c, t0, lat, pt, tk;
      bit found;
      adr = '0; dat_i = '0; we = 1'b0; sel = 4'h0; stb = 1'b0; wb_cyc = 1'b0; gi = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", {31'b0, ack}, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      chk("rst_dat", dat_o, 32'd0);
      chk("rst_gpio_o", go[31:0] | go[63:32], 32'd0);
      chk("rst_gpio_oe", goe[31:0] | goe[63:32], 32'd0);
      chk("rst_irq", {30'b0, irqb}, 32'd0);
      chk("rst_intr", {31'b0, intr}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      rd_exp(32'h04, 32'h0);
      rd_exp(32'h08, 32'h0);
      rd_exp(32'h20, 32'hFFFF_FFFF);
      chk("stall", {31'b0, stall}, 32'd0);

      wr(32'h04, 32'h0000_00F0, 4'hF); chk("gpio_wr",  go[31:0], 32'h0000_00F0);
      wr(32'h0C, 32'h0000_000F, 4'hF); chk("gpio_set", go[31:0], 32'h0000_00FF);
      wr(32'h10, 32'h0000_0030, 4'hF); chk("gpio_clr", go[31:0], 32'h0000_00CF);
      wr(32'h14, 32'h0000_0081, 4'hF); chk("gpio_tgl", go[31:0], 32'h0000_004E);
      rd_exp(32'h04, 32'h0000_004E);
      wr(32'h04, 32'hFFFF_FFFF, 4'b0001); chk("gpio_sel0", go[31:0], 32'h0000_00FF);
      wr(32'h04, 32'h12A5_3456, 4'b0100); chk("gpio_sel2", go[31:0], 32'h00A5_00FF);
      wr(32'h0C, 32'hFFFF_FFFF, 4'b1000); chk("gpio_set_sel", go[31:0], 32'hFFA5_00FF);
      rd_exp(32'h04, 32'hFFA5_00FF);
      chk("bank1_out", go[63:32], 32'h0);
      wr(32'h08, 32'hFFFF_0000, 4'hF);
      chk("gpio_oe0", goe[31:0], 32'hFFFF_0000);
      chk("gpio_oe1", goe[63:32], 32'h0);

      // bank 1 interrupt on rising edge of bit 1
      wr(32'h58, 32'h2, 4'hF);
      wr(32'h60, 32'h2, 4'hF);
      rd_exp(32'h60, 32'h2);

      gi[33] = 1'b1;
      repeat (5) @(posedge clk);
      #1 gi[33] = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      rd_exp(32'h40, 32'h0);
      rd_exp(32'h5C, 32'h0);
      chk("glitch_irq", {31'b0, irq_seen}, 32'd0);

      gi[33] = 1'b1;
      t0 = ncyc;
      found = 1'b0;
      lat = 0;
      for (int i = 0; i < 30; i++) begin
         bus(32'h40, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, r, c);
         if (r[1]) begin
            found = 1'b1;
            lat = c - 1 - t0;
            break;
         end
      end
      chk("db_found", {31'b0, found}, 32'd1);
      chk("db_lat_max", {31'b0, lat <= SS + 2 * DEB + 1}, 32'd1);
      chk("db_lat_min", {31'b0, lat >= DEB + 2}, 32'd1);
      rd_exp(32'h40, 32'h2);
      chk("irq_seen", {31'b0, irq_seen}, 32'd1);
      rd_exp(32'h5C, 32'h2);
      chk("irq_bank", {30'b0, irqb}, 32'd2);
      chk("intr_set", {31'b0, intr}, 32'd1);
      wr(32'h5C, 32'h2, 4'hF);
      chk("intr_clr", {31'b0, intr}, 32'd0);
      rd_exp(32'h5C, 32'h0);

      // edge landing on the same clock as a W1C
      gi[33] = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      rd_exp(32'h40, 32'h0);
      rd_exp(32'h5C, 32'h0);
      pt = irq_cyc - 1;
      tk = pt + DEB * ((ncyc - pt) / DEB + 1);
      wait_to(tk);
      gi[33] = 1'b1;
      wait_to(tk + 2 * DEB - 1);
      wr(32'h5C, 32'h2, 4'hF);
      rd_exp(32'h5C, 32'h2);
      chk("coinc_intr", {31'b0, intr}, 32'd1);
      wr(32'h58, 32'h0, 4'hF);
      @(posedge clk); #1;
      chk("mask_intr", {31'b0, intr}, 32'd0);
      rd_exp(32'h5C, 32'h2);

      acc_err(32'h80, 1'b0, 32'h0);
      acc_err(32'h84, 1'b1, 32'hFFFF_FFFF);
      acc_err(32'h24, 1'b1, 32'hFFFF_FFFF);
      acc_err(32'h64, 1'b0, 32'h0);
      rd_exp(32'h04, 32'hFFA5_00FF);
      rd_exp(32'h44, 32'h0);
      rd_exp(32'h60, 32'h2);

      adr = 32'h04; we = 1'b0; sel = 4'hF; stb = 1'b1; wb_cyc = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      chk("rstmid_ack", {31'b0, ack}, 32'd0);
      chk("rstmid_err", {31'b0, err}, 32'd0);
      chk("rstmid_dat", dat_o, 32'd0);
      chk("rstmid_gpio_o", go[31:0] | go[63:32], 32'd0);
      chk("rstmid_gpio_oe", goe[31:0] | goe[63:32], 32'd0);
      chk("rstmid_irq", {30'b0, irqb}, 32'd0);
      chk("rstmid_intr", {31'b0, intr}, 32'd0);
      stb = 1'b0; wb_cyc = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rd_exp(32'h20, 32'hFFFF_FFFF);
      rd_exp(32'h04, 32'h0);
      rd_exp(32'h5C, 32'h0);

      repeat (2) @(posedge clk);
      #1;
      chk("sb_empty", 32'(sbq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
